// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   kp_state_e  - debounce FSM states
//   frame_res_e - classification of one full scan frame
//   ROW_SEL*    - one-hot active-low row drive patterns
//   row_drive() - row index to row drive pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_res_e;

  localparam logic [3:0] ROW_SEL0 = 4'b1110;
  localparam logic [3:0] ROW_SEL1 = 4'b1101;
  localparam logic [3:0] ROW_SEL2 = 4'b1011;
  localparam logic [3:0] ROW_SEL3 = 4'b0111;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    row_drive = ROW_SEL0;
      2'd1:    row_drive = ROW_SEL1;
      2'd2:    row_drive = ROW_SEL2;
      default: row_drive = ROW_SEL3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 4-bit two-flop synchronizer for the keypad column inputs.
// Resets to all ones, i.e. "no contact" on the active-low columns.
//   clk, rst_n - clock, async active-low reset
//   d_i        - asynchronous column lines
//   q_o        - synchronized column lines (2-cycle latency)
module keypad_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_16.sv
// keypad_16: 4x4 matrix hex keypad scanner with frame-level debounce and a
// 4-digit hex entry shift register.
//   clk, rst_n - clock, async active-low reset
//   row        - row drive, one-hot active-low, 2^DWELL_BITS clocks per row
//   col        - column sense, active-low, asynchronous
//   clr        - synchronous clear of entry_reg
//   key_valid  - one-cycle pulse per accepted key press
//   key_code   - last accepted key (4*row + col)
//   entry_reg  - last four accepted digits, newest in [3:0]
import keypad_pkg::*;

module keypad_16 #(
  parameter int DWELL_BITS     = 11,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry_reg
);

  localparam int SW = DWELL_BITS + 2;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE_SCANS);

  // scan counter / row drive
  logic [SW-1:0] scnt_q, scnt_d;
  logic [3:0]    row_q;
  logic [1:0]    row_idx;
  logic          sample, frame_end;

  assign scnt_d    = scnt_q + 1'b1;
  assign row_idx   = scnt_q[SW-1 -: 2];
  assign sample    = &scnt_q[DWELL_BITS-1:0];
  assign frame_end = sample && (row_idx == 2'd3);

  // row is registered from the next count so it steps on the dwell wrap edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      row_q  <= ROW_SEL0;
    end else begin
      scnt_q <= scnt_d;
      row_q  <= row_drive(scnt_d[SW-1 -: 2]);
    end
  end

  // column synchronizer
  logic [3:0] col_s;

  keypad_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (col),
    .q_o   (col_s)
  );

  // frame accumulator: contact count saturates at 2, keeps last code seen
  logic [1:0] acc_cnt_q, acc_cnt_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic [1:0] row_hits, row_col;
  logic [2:0] sum;
  frame_res_e fr_res;

  always_comb begin
    row_hits = 2'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s[c]) begin
        row_hits = (row_hits == 2'd2) ? 2'd2 : row_hits + 2'd1;
        row_col  = c[1:0];
      end
    end
    sum        = {1'b0, acc_cnt_q} + {1'b0, row_hits};
    acc_cnt_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    acc_code_d = (row_hits != 2'd0) ? {row_idx, row_col} : acc_code_q;
    case (acc_cnt_d)
      2'd0:    fr_res = FR_NONE;
      2'd1:    fr_res = FR_SINGLE;
      default: fr_res = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (frame_end) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sample) begin
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  // debounce FSM, advanced only at frame end
  kp_state_e     state_q, state_d;
  logic [3:0]    cand_q, cand_d, rpt_code;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          report;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    report   = 1'b0;
    rpt_code = cand_q;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (fr_res == FR_SINGLE) begin
            cand_d = acc_code_d;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              report   = 1'b1;
              rpt_code = acc_code_d;
              state_d  = ST_PRESSED;
            end else begin
              state_d  = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (fr_res != FR_SINGLE) begin
            state_d = ST_IDLE;
          end else if (acc_code_d == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TGT) begin
              report  = 1'b1;
              state_d = ST_PRESSED;
            end
          end else begin
            cand_d = acc_code_d;
            cnt_d  = CW'(1);
          end
        end
        ST_PRESSED: begin
          if (fr_res == FR_NONE) begin
            cnt_d   = CW'(1);
            // a single quiet frame already satisfies a one-scan release
            state_d = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (fr_res == FR_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TGT) state_d = ST_IDLE;
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // outputs; clr on a report cycle keeps only the new digit
  logic        key_valid_q;
  logic [3:0]  key_code_q;
  logic [15:0] entry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= report;
      if (report) key_code_q <= rpt_code;
      if (report && clr)  entry_q <= {12'h000, rpt_code};
      else if (clr)       entry_q <= '0;
      else if (report)    entry_q <= {entry_q[11:0], rpt_code};
    end
  end

  assign row       = row_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign entry_reg = entry_q;

endmodule

// File: tb/tb_keypad_16.sv
// tb_keypad_16: scoreboard bench for keypad_16 with a 4-cycle dwell and
// 3-frame debounce. A frame-level reference model predicts reports; a
// monitor process checks row stepping, reset values and every key_valid.
module tb_keypad_16;

  localparam int DB = 3;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clr = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_reg;

  logic [15:0] keys = 16'h0000;   // pressed switches, bit 4*r+c
  int          cyc;               // cycles since reset release
  bit          done = 1'b0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ent_q[$];

  // reference model state: armed = waiting for a new press
  bit          m_armed = 1'b1;
  int          m_run = 0;
  logic [3:0]  m_run_code = 4'h0;
  int          m_quiet = 0;
  logic [15:0] m_entry = 16'h0000;

  int n_vec = 0;
  int n_err = 0;

  keypad_16 #(.DWELL_BITS(2), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .clr       (clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry_reg (entry_reg)
  );

  always #5 clk = ~clk;

  // passive switch matrix: a closed switch shorts its column to a low row
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys[4*r+c]) col[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // A report needs DB consecutive frames showing the same lone key while
  // armed; re-arming needs DB consecutive empty frames.
  task automatic model_frame(input logic [15:0] k, input bit clr_end, input int start);
    int         pc;
    logic [3:0] code;
    bit         rpt;
    pc   = $countones(k);
    code = 4'h0;
    rpt  = 1'b0;
    for (int i = 0; i < 16; i++) if (k[i]) code = 4'(i);
    if (m_armed) begin
      if (pc == 1) begin
        m_run = (m_run > 0 && code == m_run_code) ? m_run + 1 : 1;
        m_run_code = code;
        if (m_run == DB) begin
          rpt = 1'b1; m_armed = 1'b0; m_quiet = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (pc == 0) begin
        m_quiet++;
        if (m_quiet == DB) begin m_armed = 1'b1; m_run = 0; end
      end else begin
        m_quiet = 0;
      end
    end
    if (rpt && clr_end) m_entry = {12'h000, code};
    else if (clr_end)   m_entry = 16'h0000;
    else if (rpt)       m_entry = {m_entry[11:0], code};
    if (rpt) exp_q.push_back('{code, m_entry, start + FRAME});
  endtask

  task automatic apply_frame(input logic [15:0] k, input bit clr_end);
    keys = k;
    model_frame(k, clr_end, cyc);
    if (clr_end) begin
      repeat (FRAME-1) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
    end else begin
      repeat (FRAME) @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [15:0] k, input int n, input bit clr_last);
    for (int f = 0; f < n; f++) apply_frame(k, clr_last && (f == n-1));
  endtask

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (4*r + c);
  endfunction

  // monitor: all comparisons happen here
  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_t       e;
    logic [15:0] ee;
    if (!rst_n) begin
      n_vec++;
      if (row !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || entry_reg !== 16'h0) begin
        n_err++;
        $display("FAIL reset_vals: row=%b kv=%b code=%h entry=%h, want 1110 0 0 0000",
                 row, key_valid, key_code, entry_reg);
      end
    end else begin
      exp_row = 4'b1111 ^ (4'b0001 << ((cyc / 4) % 4));
      n_vec++;
      if (row !== exp_row) begin
        n_err++;
        $display("FAIL row_scan cyc=%0d: row=%b want %b", cyc, row, exp_row);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_vec++; n_err++;
        $display("FAIL missed_report: code %h due at cyc %0d, still absent at cyc %0d", e.code, e.cyc, cyc);
      end
      if (key_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_report cyc=%0d: code=%h, want no pulse", cyc, key_code);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e.code || entry_reg !== e.entry || cyc != e.cyc) begin
            n_err++;
            $display("FAIL report: code=%h entry=%h cyc=%0d, want code=%h entry=%h cyc=%0d",
                     key_code, entry_reg, cyc, e.code, e.entry, e.cyc);
          end
        end
      end
      if (ent_q.size() > 0) begin
        ee = ent_q.pop_front();
        n_vec++;
        if (entry_reg !== ee) begin
          n_err++;
          $display("FAIL entry_check: entry=%h want %h", entry_reg, ee);
        end
      end
    end
    if (done) begin
      n_vec++;
      if (exp_q.size() != 0 || entry_reg !== m_entry) begin
        n_err++;
        $display("FAIL final: pending=%0d entry=%h, want pending=0 entry=%h",
                 exp_q.size(), entry_reg, m_entry);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    logic [15:0] k;
    int          sel, len;
    // reset held for a few cycles, released just after an edge
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    hold(16'h0000, 2, 1'b0);

    // (2,1) held: one report of 9 at the end of its 3rd frame
    hold(kbit(2, 1), 6, 1'b0);
    ent_q.push_back(16'h0009);
    hold(16'h0000, 4, 1'b0);

    // digits 1..5
    for (int d = 1; d <= 5; d++) begin
      hold(kbit(d / 4, d % 4), 4, 1'b0);
      hold(16'h0000, 4, 1'b0);
    end
    ent_q.push_back(16'h2345);

    // bounce on key 7, then a two-key chord
    hold(kbit(1, 3), 1, 1'b0);
    hold(16'h0000, 1, 1'b0);
    hold(kbit(1, 3), 3, 1'b0);
    hold(16'h0000, 4, 1'b0);
    hold(kbit(0, 0) | kbit(0, 1), 5, 1'b0);
    hold(16'h0000, 4, 1'b0);

    // release glitch on key A
    hold(kbit(2, 2), 4, 1'b0);
    hold(16'h0000, 1, 1'b0);
    hold(kbit(2, 2), 3, 1'b0);
    hold(16'h0000, 4, 1'b0);

    // clr coincident with the report of key 5
    hold(kbit(1, 1), 3, 1'b1);
    ent_q.push_back(16'h0005);
    hold(16'h0000, 4, 1'b0);

    // randomized key activity
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 4);
      if (sel < 4)      k = 16'h0000;
      else if (sel < 8) k = kbit($urandom_range(0, 3), $urandom_range(0, 3));
      else begin
        k = kbit($urandom_range(0, 3), $urandom_range(0, 3));
        k = k | kbit($urandom_range(0, 3), $urandom_range(0, 3));
      end
      hold(k, len, ($urandom_range(0, 5) == 0));
    end
    hold(16'h0000, 4, 1'b0);

    // reset in the middle of a debounce, mid-frame
    hold(kbit(3, 3), 1, 1'b0);
    keys = kbit(3, 3);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    keys = 16'h0000;
    m_armed = 1'b1; m_run = 0; m_quiet = 0; m_entry = 16'h0000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    hold(kbit(1, 2), 4, 1'b0);
    ent_q.push_back(16'h0006);
    hold(16'h0000, 4, 1'b0);

    done = 1'b1;
  end

endmodule
